// File: rtl/ifu.sv
// Instruction fetch unit: PC generation, single-outstanding instruction bus
// handshake, and delivery of instructions (or NOP bubbles) into if_id.
`ifndef CPU_RESET_ADDR
`define CPU_RESET_ADDR 32'h0000_0000
`endif

module ifu #(
    parameter logic [31:0] RESET_ADDR = `CPU_RESET_ADDR,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   fetch_pc_n;
    logic [XLEN-1:0]   buf_inst;
    logic [XLEN-1:0]   buf_inst_n;
    logic [XLEN-1:0]   buf_pc;
    logic [XLEN-1:0]   buf_pc_n;
    logic [XLEN-1:0]   last_pc;
    logic [XLEN-1:0]   last_pc_n;
    logic [XLEN-1:0]   jump_tgt;
    logic              kill;
    logic              kill_n;

    assign jump_tgt = jump_addr_i & ~XLEN'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_ADDR;
            kill     <= 1'b0;
            buf_inst <= NOP_INST;
            buf_pc   <= RESET_ADDR;
            last_pc  <= RESET_ADDR;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            kill     <= kill_n;
            buf_inst <= buf_inst_n;
            buf_pc   <= buf_pc_n;
            last_pc  <= last_pc_n;
        end
    end

    // Next-state and delivery; a redirect always wins over hold and delivery.
    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        kill_n       = kill;
        buf_inst_n   = buf_inst;
        buf_pc_n     = buf_pc;
        last_pc_n    = last_pc;
        ibus_req_o   = 1'b0;
        ibus_addr_o  = fetch_pc;
        pc_o         = last_pc;
        inst_o       = NOP_INST;
        inst_valid_o = 1'b0;

        case (state)
            IDLE: begin
                state_n = REQ;
            end
            REQ: begin
                ibus_req_o = 1'b1;
                if (ibus_gnt_i) begin
                    state_n = WAIT;
                    kill_n  = jump_en_i;
                end
                if (jump_en_i) begin
                    fetch_pc_n = jump_tgt;
                end
            end
            WAIT: begin
                if (ibus_rvalid_i) begin
                    state_n = REQ;
                    kill_n  = 1'b0;
                    if (jump_en_i) begin
                        fetch_pc_n = jump_tgt;
                    end else if (!kill) begin
                        fetch_pc_n = fetch_pc + XLEN'(4);
                        if (hold_i) begin
                            buf_inst_n = ibus_rdata_i;
                            buf_pc_n   = fetch_pc;
                            state_n    = HOLD;
                        end else begin
                            inst_o       = ibus_rdata_i;
                            pc_o         = fetch_pc;
                            inst_valid_o = 1'b1;
                            last_pc_n    = fetch_pc;
                        end
                    end
                end else if (jump_en_i) begin
                    kill_n     = 1'b1;
                    fetch_pc_n = jump_tgt;
                end
            end
            HOLD: begin
                if (jump_en_i) begin
                    fetch_pc_n = jump_tgt;
                    state_n    = REQ;
                end else if (!hold_i) begin
                    inst_o       = buf_inst;
                    pc_o         = buf_pc;
                    inst_valid_o = 1'b1;
                    last_pc_n    = buf_pc;
                    state_n      = REQ;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: bus responder, transaction-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_ifu;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] KEY        = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;

    int checks = 0;
    int failures = 0;
    int gnt_delay = 0;
    int rv_delay = 1;

    ifu #(.RESET_ADDR(RESET_ADDR), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold_i       (hold),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .ibus_req_o   (req),
        .ibus_addr_o  (addr),
        .ibus_gnt_i   (gnt),
        .ibus_rvalid_i(rvalid),
        .ibus_rdata_i (rdata),
        .pc_o         (pc),
        .inst_o       (inst),
        .inst_valid_o (valid)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Bus slave: grants after gnt_delay request cycles, answers rv_delay cycles later.
    int          wait_cnt = 0;
    int          pend = 0;
    logic [31:0] pend_addr = 32'h0;
    initial begin
        forever begin
            @(negedge clk);
            rvalid = (pend == 1);
            rdata  = pend_addr ^ KEY;
            if (pend > 0) pend--;
            gnt = 1'b0;
            if (rst_n && req) begin
                if (wait_cnt >= gnt_delay) begin
                    gnt       = 1'b1;
                    pend      = rv_delay;
                    pend_addr = addr;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Reference model: tracks "request in flight", "its response is dead",
    // "an instruction is parked", the next address to fetch and last delivered PC.
    logic        m_started = 1'b0;
    logic        m_inflight = 1'b0;
    logic        m_dead = 1'b0;
    logic        m_bufv = 1'b0;
    logic [31:0] m_buf_inst = 32'h0;
    logic [31:0] m_buf_pc = 32'h0;
    logic [31:0] m_resp = 32'h0;
    logic [31:0] m_next = RESET_ADDR;
    logic [31:0] m_last = RESET_ADDR;

    initial begin
        forever begin
            logic        e_req;
            logic        e_valid;
            logic [31:0] e_pc;
            logic [31:0] e_inst;
            logic [31:0] jt;
            logic [31:0] old_next;
            @(negedge clk);
            #3;
            if (!rst_n) begin
                chk("rst_req", 32'(req), 32'd0);
                chk("rst_addr", addr, RESET_ADDR);
                chk("rst_pc", pc, RESET_ADDR);
                chk("rst_inst", inst, NOP);
                chk("rst_valid", 32'(valid), 32'd0);
                m_started  = 1'b0;
                m_inflight = 1'b0;
                m_dead     = 1'b0;
                m_bufv     = 1'b0;
                m_next     = RESET_ADDR;
                m_last     = RESET_ADDR;
            end else begin
                jt       = jump_addr & 32'hFFFF_FFFC;
                old_next = m_next;
                e_req    = m_started && !m_inflight && !m_bufv;
                e_valid  = 1'b0;
                e_pc     = m_last;
                e_inst   = NOP;
                if (e_req) begin
                    if (gnt) begin
                        m_inflight = 1'b1;
                        m_resp     = m_next;
                        m_dead     = jump_en;
                    end
                    if (jump_en) m_next = jt;
                end else if (m_inflight) begin
                    if (rvalid) begin
                        m_inflight = 1'b0;
                        if (!m_dead && !jump_en) begin
                            m_next = m_resp + 32'd4;
                            if (hold) begin
                                m_bufv     = 1'b1;
                                m_buf_inst = rdata;
                                m_buf_pc   = m_resp;
                            end else begin
                                e_valid = 1'b1;
                                e_pc    = m_resp;
                                e_inst  = rdata;
                            end
                        end
                        if (jump_en) m_next = jt;
                        m_dead = 1'b0;
                    end else if (jump_en) begin
                        m_dead = 1'b1;
                        m_next = jt;
                    end
                end else if (m_bufv) begin
                    if (jump_en) begin
                        m_bufv = 1'b0;
                        m_next = jt;
                    end else if (!hold) begin
                        m_bufv  = 1'b0;
                        e_valid = 1'b1;
                        e_pc    = m_buf_pc;
                        e_inst  = m_buf_inst;
                    end
                end
                chk("req", 32'(req), 32'(e_req));
                if (e_req) chk("addr", addr, old_next);
                chk("valid", 32'(valid), 32'(e_valid));
                chk("pc", pc, e_pc);
                chk("inst", inst, e_inst);
                if (e_valid) m_last = e_pc;
                m_started = 1'b1;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_next_req(string name, logic [31:0] a);
        int n = 0;
        do begin
            step();
            n++;
        end while (!req && n < 40);
        chk({name, "_seen"}, 32'(req), 32'd1);
        if (req) chk(name, addr, a);
    endtask

    task automatic expect_deliver(string name, logic [31:0] p, logic [31:0] i);
        int n = 0;
        do begin
            step();
            n++;
        end while (!valid && n < 40);
        chk({name, "_seen"}, 32'(valid), 32'd1);
        if (valid) begin
            chk({name, "_pc"}, pc, p);
            chk({name, "_inst"}, inst, i);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("init_req", 32'(req), 32'd0);
        chk("init_pc", pc, 32'h0);
        chk("init_inst", inst, 32'h0000_0013);
        rst_n = 1'b1;

        // Free run from reset
        expect_next_req("s1_req0", 32'h0);
        expect_deliver("s1_d0", 32'h0, 32'hA5A5_A5A5);
        expect_deliver("s1_d4", 32'h4, 32'hA5A5_A5A1);

        // Hold spanning the response for PC 8
        expect_next_req("s2_req8", 32'h8);
        hold = 1'b1;
        step();
        chk("s2_b_req", 32'(req), 32'd0);
        chk("s2_b_pc", pc, 32'h4);
        step();
        chk("s2_h_req", 32'(req), 32'd0);
        chk("s2_h_pc", pc, 32'h4);
        chk("s2_h_inst", inst, 32'h0000_0013);
        step();
        hold = 1'b0;
        #1;
        chk("s2_rel_valid", 32'(valid), 32'd1);
        chk("s2_rel_pc", pc, 32'h8);
        chk("s2_rel_inst", inst, 32'hA5A5_A5AD);
        rv_delay = 2;
        step();
        chk("s2_next_req", 32'(req), 32'd1);
        chk("s3_addr12", addr, 32'hC);

        // Redirect while waiting for PC 12
        step();
        jump_en   = 1'b1;
        jump_addr = 32'h0000_0101;
        step();
        jump_en  = 1'b0;
        rv_delay = 1;
        #1;
        chk("s3_drop_valid", 32'(valid), 32'd0);
        expect_next_req("s3_req100", 32'h100);
        expect_deliver("s3_d100", 32'h100, 32'hA5A5_A4A5);

        // Redirect in the grant cycle
        expect_next_req("s4_req104", 32'h104);
        jump_en   = 1'b1;
        jump_addr = 32'h10;
        step();
        jump_en = 1'b0;
        expect_next_req("s4_req10", 32'h10);
        jump_en   = 1'b1;
        jump_addr = 32'h200;
        step();
        jump_en = 1'b0;
        expect_next_req("s4_req200", 32'h200);
        expect_deliver("s4_d200", 32'h200, 32'hA5A5_A7A5);

        // Slow grant with a retarget before it
        gnt_delay = 4;
        expect_next_req("s5_req204", 32'h204);
        step();
        jump_en   = 1'b1;
        jump_addr = 32'h300;
        step();
        jump_en = 1'b0;
        #1;
        chk("s5_retarget_req", 32'(req), 32'd1);
        chk("s5_retarget", addr, 32'h300);
        expect_deliver("s5_d300", 32'h300, 32'hA5A5_A6A5);
        gnt_delay = 0;

        // Address wrap and reset mid-transaction
        expect_next_req("s6_req304", 32'h304);
        jump_en   = 1'b1;
        jump_addr = 32'hFFFF_FFFF;
        step();
        jump_en = 1'b0;
        expect_next_req("s6_reqffc", 32'hFFFF_FFFC);
        expect_deliver("s6_dffc", 32'hFFFF_FFFC, 32'h5A5A_5A59);
        rv_delay = 3;
        expect_next_req("s6_wrap", 32'h0);
        step();
        rst_n = 1'b0;
        #1;
        chk("s6_async_req", 32'(req), 32'd0);
        chk("s6_async_addr", addr, 32'h0);
        chk("s6_async_pc", pc, 32'h0);
        chk("s6_async_inst", inst, 32'h0000_0013);
        chk("s6_async_valid", 32'(valid), 32'd0);
        rv_delay = 1;
        step();
        rst_n = 1'b1;
        expect_next_req("s6_rereq", 32'h0);
        expect_deliver("s6_redeliver", 32'h0, 32'hA5A5_A5A5);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
